// File: rtl/lsu_axi_master.sv
// AXI4-Lite initiator for single LSU load/store requests, one transaction in flight.
// Optional misaligned-access rejection is enabled by defining LSU_AXI_MISALIGN_CHECK_EN.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  input  logic [1:0]        req_size,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_e;

  state_e              state_q, state_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, resp_rdata_q, resp_rdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                misaligned;

`ifdef LSU_AXI_MISALIGN_CHECK_EN
  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end
`else
  logic unused_req_size;
  assign unused_req_size = ^req_size;
  assign misaligned      = 1'b0;
`endif

  // NOTE: every register, including the data holding registers, is cleared by the
  // synchronous reset so a transaction cut short leaves nothing behind on the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // NOTE: each _d starts as its _q so every path through the case assigns it; no latches.
  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else if (req_we) begin
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          resp_rdata_d = rdata;
          resp_err_d   = |rresp;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; a channel already done counts as done.
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          resp_err_d   = |bresp;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          bready_d     = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: delay-programmable AXI responder, protocol monitor
// and a scoreboard of expected LSU responses.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0, viol = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, fire_cyc = 0;
  logic [31:0] ar_addr_seen = '0, aw_addr_seen = '0, w_data_seen = '0;
  logic [3:0]  w_strb_seen = '0;

  // Responder programming: wait cycles per channel and the read/write response contents.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] rsp_rdata = '0;
  logic [1:0]  rsp_rresp = '0, rsp_bresp = '0;

  // Protocol monitor: handshake counts and valid-withdrawal / path-overlap violations.
  logic p_arv = 0, p_ar_hs = 0, p_awv = 0, p_aw_hs = 0, p_wv = 0, p_w_hs = 0;
  logic [31:0] p_araddr = '0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (p_arv && !p_ar_hs && (!arvalid || araddr !== p_araddr)) viol = viol + 1;
      if (p_awv && !p_aw_hs && !awvalid) viol = viol + 1;
      if (p_wv && !p_w_hs && !wvalid) viol = viol + 1;
      if ((arvalid || rready) && (awvalid || wvalid || bready)) viol = viol + 1;
      if (bready && (awvalid || wvalid)) viol = viol + 1;
      if (arvalid && arready) begin ar_n = ar_n + 1; ar_addr_seen = araddr; end
      if (rvalid && rready) r_n = r_n + 1;
      if (awvalid && awready) begin aw_n = aw_n + 1; aw_hs_cyc = cyc; aw_addr_seen = awaddr; end
      if (wvalid && wready) begin w_n = w_n + 1; w_hs_cyc = cyc; w_data_seen = wdata; w_strb_seen = wstrb; end
      if (bvalid && bready) b_n = b_n + 1;
      p_arv = arvalid; p_ar_hs = arvalid && arready; p_araddr = araddr;
      p_awv = awvalid; p_aw_hs = awvalid && awready;
      p_wv = wvalid;   p_w_hs = wvalid && wready;
    end
  end

  always @(posedge clk) begin
    automatic logic ar_f = arvalid && arready;
    automatic logic r_f  = rvalid && rready;
    automatic logic aw_f = awvalid && awready;
    automatic logic w_f  = wvalid && wready;
    automatic logic b_f  = bvalid && bready;
    #1;
    if (ar_f || !arvalid) begin arready = 0; ar_cnt = 0; end
    else if (ar_cnt == ar_dly) arready = 1;
    else ar_cnt = ar_cnt + 1;
    if (r_f || !rready) begin rvalid = 0; r_cnt = 0; end
    else if (r_cnt == r_dly) begin rvalid = 1; rdata = rsp_rdata; rresp = rsp_rresp; end
    else r_cnt = r_cnt + 1;
    if (aw_f || !awvalid) begin awready = 0; aw_cnt = 0; end
    else if (aw_cnt == aw_dly) awready = 1;
    else aw_cnt = aw_cnt + 1;
    if (w_f || !wvalid) begin wready = 0; w_cnt = 0; end
    else if (w_cnt == w_dly) wready = 1;
    else w_cnt = w_cnt + 1;
    if (b_f || !bready) begin bvalid = 0; b_cnt = 0; end
    else if (b_cnt == b_dly) begin bvalid = 1; bresp = rsp_bresp; end
    else b_cnt = b_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [1:0] sz,
                        input logic push, input logic [31:0] exp_data, input logic exp_err);
    check("req_ready_before_fire", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws; req_size = sz;
    if (push) sb.push_back('{data: exp_data, err: exp_err});
    tick();
    fire_cyc = cyc;
    req_valid = 0; req_we = 0;
  endtask

  // Latency is counted so that a response first sampled high at edge T+n gives n.
  task automatic wait_resp(input string tag, input int exp_lat, input int hold);
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) begin seen = 1; break; end
      tick();
    end
    check({tag, "_resp_seen"}, {31'd0, seen}, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      if (seen) begin
        check({tag, "_latency"}, cyc + 1 - fire_cyc, exp_lat);
        check({tag, "_rdata"}, resp_rdata, e.data);
        check({tag, "_err"}, resp_err, e.err);
        for (int h = 0; h < hold; h++) begin
          tick();
          check({tag, "_hold_valid"}, resp_valid, 1);
          check({tag, "_hold_rdata"}, resp_rdata, e.data);
          check({tag, "_hold_err"}, resp_err, e.err);
          check({tag, "_hold_req_ready"}, req_ready, 0);
        end
        resp_ready = 1;
        tick();
        resp_ready = 0;
        check({tag, "_resp_dropped"}, resp_valid, 0);
        check({tag, "_idle_again"}, req_ready, 1);
      end
    end
  endtask

  int ar0, r0, aw0, w0, b0;

  initial begin
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata_wstrb", {wdata[27:0], wstrb}, 0);
    check("rst_resp", {resp_rdata[30:0], resp_err}, 0);
    rst = 1;
    tick();

    // Zero-wait load.
    rsp_rdata = 32'h0000_1234; rsp_rresp = 2'b00;
    ar0 = ar_n; r0 = r_n;
    do_req(0, 32'h1001_0000, 0, 0, 2, 1, 32'h0000_1234, 0);
    check("ld0_arvalid", arvalid, 1);
    check("ld0_araddr", araddr, 32'h1001_0000);
    wait_resp("ld0", 3, 0);
    check("ld0_ar_count", ar_n - ar0, 1);
    check("ld0_r_count", r_n - r0, 1);

    // Load with AR delayed 3 and R delayed 2 more.
    ar_dly = 3; r_dly = 2; rsp_rdata = 32'hCAFE_0042;
    ar0 = ar_n; r0 = r_n;
    do_req(0, 32'h1001_0010, 0, 0, 2, 1, 32'hCAFE_0042, 0);
    wait_resp("ld_slow", 8, 0);
    check("ld_slow_ar_count", ar_n - ar0, 1);
    check("ld_slow_r_count", r_n - r0, 1);
    check("ld_slow_ar_addr", ar_addr_seen, 32'h1001_0010);
    ar_dly = 0; r_dly = 0;

    // Store: W accepted two cycles before AW.
    aw_dly = 2; w_dly = 0; rsp_bresp = 2'b00;
    aw0 = aw_n; w0 = w_n; b0 = b_n;
    do_req(1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 2, 1, 32'h0, 0);
    wait_resp("st", 5, 0);
    check("st_aw_count", aw_n - aw0, 1);
    check("st_w_count", w_n - w0, 1);
    check("st_b_count", b_n - b0, 1);
    check("st_w_before_aw", aw_hs_cyc - w_hs_cyc, 2);
    check("st_awaddr", aw_addr_seen, 32'h1001_0004);
    check("st_wdata", w_data_seen, 32'hDEAD_BEEF);
    check("st_wstrb", w_strb_seen, 4'hF);
    aw_dly = 0;

    // Load with SLVERR; LSU holds off the response for 4 cycles.
    rsp_rdata = 32'hBAD0_0001; rsp_rresp = 2'b10;
    do_req(0, 32'h1001_0008, 0, 0, 2, 1, 32'hBAD0_0001, 1);
    wait_resp("ld_err", 3, 4);
    rsp_rresp = 2'b00;

    // Store with DECERR on B.
    rsp_bresp = 2'b11;
    do_req(1, 32'h1001_0020, 32'h0000_00FF, 4'h1, 0, 1, 32'h0, 1);
    wait_resp("st_err", 3, 0);
    rsp_bresp = 2'b00;

    // Reset while stuck in WR_REQ drops the store silently.
    aw_dly = 20; w_dly = 20; b0 = b_n;
    do_req(1, 32'h1001_0030, 32'h1111_2222, 4'h3, 1, 0, 32'h0, 0);
    tick();
    check("mid_awvalid", {awvalid, wvalid}, 2'b11);
    rst = 0;
    tick();
    check("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_resp_valid", resp_valid, 0);
    rst = 1; aw_dly = 0; w_dly = 0;
    tick(); tick();
    check("mid_rst_no_b", b_n - b0, 0);
    check("mid_rst_no_resp", resp_valid, 0);
    rsp_rdata = 32'h55AA_55AA;
    do_req(0, 32'h1001_000C, 0, 0, 2, 1, 32'h55AA_55AA, 0);
    wait_resp("ld_after_rst", 3, 0);

    // Word load from a half-aligned address.
    ar0 = ar_n;
    rsp_rdata = 32'h0000_00AB;
`ifdef LSU_AXI_MISALIGN_CHECK_EN
    do_req(0, 32'h1001_0002, 0, 0, 2, 1, 32'h0, 1);
    check("mis_no_arvalid", arvalid, 0);
    wait_resp("mis", 1, 0);
    check("mis_ar_count", ar_n - ar0, 0);
`else
    do_req(0, 32'h1001_0002, 0, 0, 2, 1, 32'h0000_00AB, 0);
    check("mis_araddr", araddr, 32'h1001_0002);
    wait_resp("mis", 3, 0);
    check("mis_ar_count", ar_n - ar0, 1);
`endif

    check("protocol_violations", viol, 0);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
